// File: rtl/multi_channel_signature_analyzer_pkg.sv
// Shared types and MISR helper for the multi-lane signature analyzer.
package bist_sig_pkg;

    localparam int unsigned SIG_MAX_W = 64;
    localparam logic [SIG_MAX_W-1:0] POLY_DEFAULT = 64'h1B;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } st_sig_state;

    // One Galois MISR step on a w-bit register carried in a 64-bit container.
    // Bits at and above w are masked off so narrower lanes behave exactly.
    function automatic logic [SIG_MAX_W-1:0] misr_next(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] data,
        input logic [SIG_MAX_W-1:0] poly,
        input int unsigned          w
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] top;
        mask = (w >= SIG_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        top  = sig >> (w - 1);
        return (((sig << 1) ^ (top[0] ? poly : '0)) ^ data) & mask;
    endfunction

endpackage

// File: rtl/multi_channel_signature_analyzer_if.sv
// Controller/analyzer bundle: run control, golden values, DUT streams, results.
interface multi_channel_signature_analyzer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                         start_i;
    logic                         abort_i;
    logic                         bypass_i;
    logic [DATA_WIDTH-1:0]        seed_i;
    logic [CNT_WIDTH-1:0]         window_i;
    logic [NUM_CH*DATA_WIDTH-1:0] golden_i;
    logic [NUM_CH-1:0]            dut_valid_i;
    logic [NUM_CH*DATA_WIDTH-1:0] dut_data_i;
    logic                         busy_o;
    logic                         done_o;
    logic                         pass_o;
    logic                         aborted_o;
    logic [NUM_CH-1:0]            fail_mask_o;
    logic [NUM_CH*DATA_WIDTH-1:0] sig_o;

    // Analyzer side.
    modport slave (
        input  start_i, abort_i, bypass_i, seed_i, window_i, golden_i,
               dut_valid_i, dut_data_i,
        output busy_o, done_o, pass_o, aborted_o, fail_mask_o, sig_o
    );

    // BIST controller / stream source side.
    modport master (
        output start_i, abort_i, bypass_i, seed_i, window_i, golden_i,
               dut_valid_i, dut_data_i,
        input  busy_o, done_o, pass_o, aborted_o, fail_mask_o, sig_o
    );
endinterface

// File: rtl/multi_channel_signature_analyzer_lane.sv
// One MISR lane: signature register plus saturating beat counter.
module sig_lane
    import bist_sig_pkg::*;
#(
    parameter int                   DATA_WIDTH = 64,
    parameter int                   CNT_WIDTH  = 16,
    parameter logic [SIG_MAX_W-1:0] POLY       = POLY_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load,
    input  logic                  accept,
    input  logic                  bypass,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CNT_WIDTH-1:0]  window,
    output logic [DATA_WIDTH-1:0] sig,
    output logic                  complete
);
    logic [DATA_WIDTH-1:0] sig_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [SIG_MAX_W-1:0]  nxt;
    logic                  take;

    // Beats past the window are dropped, which also keeps the counter saturated.
    assign take = accept && (cnt_q < window);
    assign nxt  = misr_next(SIG_MAX_W'(sig_q), SIG_MAX_W'(data), POLY, DATA_WIDTH);

    // Seed load, then compact (or raw-capture) each accepted beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sig_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sig_q <= seed;
            cnt_q <= '0;
        end else if (take) begin
            sig_q <= bypass ? data : nxt[DATA_WIDTH-1:0];
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sig      = sig_q;
    assign complete = (cnt_q == window);
endmodule

// File: rtl/multi_channel_signature_analyzer.sv
// Multi-lane BIST response compactor: FSM, per-lane MISRs, golden compare.
module multi_channel_signature_analyzer
    import bist_sig_pkg::*;
#(
    parameter int                   DATA_WIDTH = 64,
    parameter int                   NUM_CH     = 4,
    parameter int                   CNT_WIDTH  = 16,
    parameter logic [SIG_MAX_W-1:0] POLY       = POLY_DEFAULT
) (
    input logic clk_i,
    input logic rstn_i,
    multi_channel_signature_analyzer_if.slave bus
);
    st_sig_state state_q, state_d;

    logic [CNT_WIDTH-1:0]                window_q;
    logic                                aborted_q;
    logic                                pass_q;
    logic [NUM_CH-1:0]                   fail_q;
    logic [NUM_CH-1:0]                   complete;
    logic [NUM_CH-1:0]                   mismatch;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]   lane_sig;

    // Lanes: loaded in SEED, fed only while RUN.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        sig_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .POLY       (POLY)
        ) u_lane (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .load     (state_q == SEED),
            .accept   ((state_q == RUN) && bus.dut_valid_i[k]),
            .bypass   (bus.bypass_i),
            .seed     (bus.seed_i),
            .data     (bus.dut_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .window   (window_q),
            .sig      (lane_sig[k]),
            .complete (complete[k])
        );
        assign mismatch[k] = (lane_sig[k] != bus.golden_i[k*DATA_WIDTH +: DATA_WIDTH]);
        assign bus.sig_o[k*DATA_WIDTH +: DATA_WIDTH] = lane_sig[k];
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state; abort beats completion in the same RUN cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start_i) state_d = SEED;
            SEED:       state_d = RUN;
            RUN: begin
                if (bus.abort_i)      state_d = DONE;
                else if (&complete)   state_d = COMPARE;
            end
            COMPARE:    state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Window latch and result registers; cleared at the start of every run.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            window_q  <= '0;
            aborted_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            case (state_q)
                SEED: begin
                    window_q  <= bus.window_i;
                    aborted_q <= 1'b0;
                    pass_q    <= 1'b0;
                    fail_q    <= '0;
                end
                RUN: if (bus.abort_i) begin
                    aborted_q <= 1'b1;
                    pass_q    <= 1'b0;
                    fail_q    <= '1;
                end
                COMPARE: begin
                    fail_q <= mismatch;
                    pass_q <= ~|mismatch;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o      = (state_q == SEED) || (state_q == RUN) || (state_q == COMPARE);
    assign bus.done_o      = (state_q == DONE);
    assign bus.pass_o      = pass_q;
    assign bus.aborted_o   = aborted_q;
    assign bus.fail_mask_o = fail_q;
endmodule

// File: tb/tb_multi_channel_signature_analyzer.sv
// Directed bench for the signature analyzer with hand-computed expectations.
module tb_multi_channel_signature_analyzer;
    localparam int DW = 64;
    localparam int NC = 4;
    localparam int CW = 16;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    multi_channel_signature_analyzer_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) bus ();

    multi_channel_signature_analyzer #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // IDLE/DONE -> SEED -> RUN; returns positioned in the first RUN cycle.
    task automatic begin_run(input logic [DW-1:0] seed, input logic [CW-1:0] win);
        bus.seed_i   = seed;
        bus.window_i = win;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        tick();
    endtask

    // n beats on every lane with the same packed data word.
    task automatic beats(input int n, input logic [NC*DW-1:0] data);
        bus.dut_valid_i = '1;
        bus.dut_data_i  = data;
        for (int i = 0; i < n; i++) tick();
        bus.dut_valid_i = '0;
        bus.dut_data_i  = '0;
    endtask

    initial begin
        bus.start_i = 0; bus.abort_i = 0; bus.bypass_i = 0;
        bus.seed_i = '0; bus.window_i = '0; bus.golden_i = '0;
        bus.dut_valid_i = '0; bus.dut_data_i = '0;

        // Reset state
        #12;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_pass", bus.pass_o, 0);
        chk("rst_sig", bus.sig_o, 0);
        rstn_i = 1'b1;
        tick();

        // Abort outside RUN is ignored
        bus.abort_i = 1; tick(); bus.abort_i = 0;
        chk("idle_abort_done", bus.done_o, 0);
        chk("idle_abort_aborted", bus.aborted_o, 0);

        // Zero path: last beat at edge t, COMPARE after t+1, DONE after t+2
        bus.golden_i = '0;
        begin_run(64'h0, 16'd4);
        chk("zero_busy", bus.busy_o, 1);
        beats(4, '0);
        chk("zero_t0_done", bus.done_o, 0);
        tick();
        chk("zero_t1_done", bus.done_o, 0);
        tick();
        chk("zero_t2_done", bus.done_o, 1);
        chk("zero_busy_end", bus.busy_o, 0);
        chk("zero_pass", bus.pass_o, 1);
        chk("zero_mask", bus.fail_mask_o, 0);
        chk("zero_sig", bus.sig_o, 0);
        tick();
        chk("zero_hold", bus.done_o, 1);

        // Shift: seed 1, four zero beats -> 0x10
        bus.golden_i = {NC{64'h10}};
        begin_run(64'h1, 16'd4);
        beats(4, '0);
        tick(); tick();
        chk("shift_sig", bus.sig_o, {NC{64'h10}});
        chk("shift_pass", bus.pass_o, 1);

        // Feedback: MSB set, one zero beat -> taps 0x1B
        bus.golden_i = {NC{64'h1B}};
        begin_run(64'h8000_0000_0000_0000, 16'd1);
        beats(1, '0);
        tick(); tick();
        chk("fb_sig", bus.sig_o, {NC{64'h1B}});
        chk("fb_pass", bus.pass_o, 1);

        // Fault: lane 2 gets 1 on beat 0 -> 1,2,4,8
        bus.golden_i = '0;
        begin_run(64'h0, 16'd4);
        beats(1, {64'h0, 64'h1, 64'h0, 64'h0});
        beats(3, '0);
        tick(); tick();
        chk("fault_mask", bus.fail_mask_o, 4'b0100);
        chk("fault_pass", bus.pass_o, 0);
        chk("fault_sig", bus.sig_o, {64'h0, 64'h8, 64'h0, 64'h0});

        // Skew: lane 0 data 1..6 (last two dropped) -> 1,0,3,2; lane 3 every third cycle
        bus.golden_i = {64'h0, 64'h0, 64'h0, 64'h2};
        begin_run(64'h0, 16'd4);
        for (int c = 0; c < 10; c++) begin
            bus.dut_valid_i = {(c % 3 == 0), (c < 4), (c < 4), (c < 6)};
            bus.dut_data_i  = {192'h0, 64'(c + 1)};
            if (c == 5) bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            if (c == 8) begin
                chk("skew_wait_busy", bus.busy_o, 1);
                chk("skew_wait_done", bus.done_o, 0);
            end
        end
        bus.dut_valid_i = '0; bus.dut_data_i = '0;
        tick();
        chk("skew_t1_done", bus.done_o, 0);
        tick();
        chk("skew_t2_done", bus.done_o, 1);
        chk("skew_sig", bus.sig_o, {192'h0, 64'h2});
        chk("skew_pass", bus.pass_o, 1);

        // Abort after 2 beats
        bus.golden_i = '0;
        begin_run(64'h0, 16'd4);
        beats(2, '0);
        bus.abort_i = 1; tick(); bus.abort_i = 0;
        chk("abort_done", bus.done_o, 1);
        chk("abort_flag", bus.aborted_o, 1);
        chk("abort_mask", bus.fail_mask_o, 4'b1111);
        chk("abort_pass", bus.pass_o, 0);

        // Restart with window 0: SEED, RUN, COMPARE, DONE
        bus.golden_i = {NC{64'h1234}};
        begin_run(64'h1234, 16'd0);
        chk("w0_cleared", bus.aborted_o, 0);
        tick(); tick();
        chk("w0_done", bus.done_o, 1);
        chk("w0_pass", bus.pass_o, 1);
        chk("w0_aborted", bus.aborted_o, 0);
        chk("w0_sig", bus.sig_o, {NC{64'h1234}});

        // Reset mid-RUN
        begin_run(64'h55, 16'd4);
        beats(2, {NC{64'h3}});
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_done", bus.done_o, 0);
        chk("mid_rst_sig", bus.sig_o, 0);
        chk("mid_rst_mask", bus.fail_mask_o, 0);
        rstn_i = 1'b1;
        tick();
        chk("mid_rst_idle", bus.busy_o, 0);

        // Bypass capture: A, B, C -> C
        bus.bypass_i = 1;
        bus.golden_i = {NC{64'hC}};
        begin_run(64'h77, 16'd3);
        beats(1, {NC{64'hA}});
        beats(1, {NC{64'hB}});
        beats(1, {NC{64'hC}});
        bus.bypass_i = 0;
        tick(); tick();
        chk("byp_sig", bus.sig_o, {NC{64'hC}});
        chk("byp_pass", bus.pass_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multi_channel_signature_analyzer.md
Name: multi_channel_signature_analyzer

Overview:
- Next-generation BIST response compactor: NUM_CH independent MISR lanes, each compacting one DUT output stream over a programmable beat window.
- Compares every lane signature against a per-lane golden value and reports per-lane pass/fail.
- Supports restart without reset, abort, and bypass (raw capture).
- Sits between the systolic-array outputs and the BIST controller.

Parameters:
- DATA_WIDTH, 64, width of each lane's data and signature.
- NUM_CH, 4, number of independent lanes (>=1).
- CNT_WIDTH, 16, width of window/beat counters.
- POLY, 64'h1B, Galois feedback taps (x^64+x^4+x^3+x+1), truncated to DATA_WIDTH.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begins a run from IDLE or DONE
- abort_i  in  1  terminates a run in RUN
- bypass_i  in  1  lane registers capture raw data instead of compacting; sampled each beat
- seed_i  in  DATA_WIDTH  initial signature for all lanes
- window_i  in  CNT_WIDTH  beats per lane to compact; sampled on start
- golden_i  in  NUM_CH*DATA_WIDTH  expected signatures, lane k at [k*DATA_WIDTH +: DATA_WIDTH]; sampled in COMPARE
- dut_valid_i  in  NUM_CH  per-lane beat valid
- dut_data_i  in  NUM_CH*DATA_WIDTH  per-lane data, same packing
- busy_o  out  1  state is SEED, RUN or COMPARE
- done_o  out  1  state is DONE
- pass_o  out  1  done, not aborted, fail_mask all zero
- aborted_o  out  1  last run ended by abort
- fail_mask_o  out  NUM_CH  per-lane mismatch
- sig_o  out  NUM_CH*DATA_WIDTH  current lane signatures

Behaviour:
- Reset: state IDLE. All signatures 0, counters 0, window register 0. busy_o, done_o, pass_o and aborted_o are 0. fail_mask_o is 0. Reset is effective in any state, including mid-run.
- FSM states: IDLE, SEED, RUN, COMPARE, DONE.
- IDLE/DONE -> SEED on start_i. start_i is ignored in SEED, RUN and COMPARE.
- SEED (1 cycle):
  - Every lane signature <= seed_i and every counter <= 0.
  - window_i is latched; aborted_o and fail_mask_o are cleared.
  - Next state RUN.
- RUN, per lane k:
  - A beat is accepted when dut_valid_i[k]=1 and cnt[k] < window.
  - On an accepted beat, cnt[k]++.
  - Signature update when bypass_i=0: sig <= ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ data.
  - Signature update when bypass_i=1: sig <= data.
  - Beats arriving after cnt[k] reaches window are dropped.
  - Lanes advance independently and may be skewed.
- RUN exit conditions:
  - RUN -> COMPARE when all cnt[k]==window, evaluated on registered counters.
  - window==0 goes to COMPARE on the first RUN cycle with sig=seed.
  - abort_i in RUN -> DONE with aborted_o=1 and fail_mask_o all ones. Abort takes priority over completion in the same cycle.
  - abort_i is ignored outside RUN.
- COMPARE (1 cycle): fail_mask_o[k] <= (sig[k] != golden_k); next state DONE.
- DONE:
  - Outputs hold until the next start_i.
  - pass_o = ~aborted_o & ~|fail_mask_o, registered.
- Latency: if the last beat is accepted at edge t, done_o rises after edge t+2.
- sig_o is always the live lane registers and is frozen outside RUN.
- Counters saturate at window and never wrap.
- Restart from DONE clears the previous results in SEED.

Decomposition:
- Shared package bist_sig_pkg:
  - State enum st_sig_state {IDLE, SEED, RUN, COMPARE, DONE}.
  - Default POLY constant.
  - Function misr_next(sig, data, poly).
- Sub-module sig_lane, instantiated NUM_CH times in a generate loop. It holds one signature register and one counter, with ports for load (seed), accept, bypass, data and window, and outputs sig and complete.
- The top level holds the FSM, compare logic and result registers.

Test Plan:
- Zero path: seed=0, window=4, all lanes valid with data 0 for 4 cycles, golden 0 -> sig_o lanes 0, done_o at edge t+2, pass_o=1, fail_mask_o=0.
- Shift check: seed=1, window=4, data 0, lane golden 0x10 -> each sig=0x10, pass_o=1. Feedback check: seed=1<<63, window=1, data 0 -> sig=0x1B.
- Fault injection: same run as the zero path, but lane 2 receives data 0x1 on beat 0 -> fail_mask_o=4'b0100, pass_o=0, other lanes 0.
- Skew and extra beats: lane 0 valid every cycle, lane 3 valid every third cycle, 2 extra beats on lane 0 after its window -> extra beats ignored, COMPARE only after lane 3's 4th beat.
- Abort, restart, window=0: abort_i in RUN after 2 beats -> DONE, aborted_o=1, fail_mask_o=4'b1111, pass_o=0. Then start_i with window=0 and golden=seed -> pass_o=1, aborted_o=0.
- Reset and bypass: rstn_i low mid-RUN -> all outputs 0 and state IDLE. A bypass run with window=3, data 0xA,0xB,0xC -> sig_o=0xC.
